prime_sched: RTL

Round-robin scheduler that shares one sequential trial-division prime engine among NREQ requesters. Each requester offers a W-bit number over valid/ready. The scheduler grants one request at a time and runs the divisor search one divisor per cycle, stopping at the first factor or once the divisor passes the square root. It returns a tagged prime/not-prime response over valid/ready. It replaces per-consumer combinational prime checkers, trading latency for area.

---
 rtl/prime_sched_pkg.sv | 22 ++
 rtl/prime_sched_if.sv | 30 +++
 rtl/prime_trial_engine.sv | 63 ++++++
 rtl/prime_sched.sv | 115 +++++++++++
 4 files changed

// File: rtl/prime_sched_pkg.sv
// Shared types and helpers for the prime_sched round-robin primality scheduler.
package prime_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        DONE
    } state_e;

    localparam int NREQ_DEF = 2;
    localparam int W_DEF    = 8;

    // Operands are widened to MAXW before squaring so the product never wraps.
    localparam int MAXW = 32;

    function automatic logic isqrt_bound(input logic [MAXW-1:0] d, input logic [MAXW-1:0] num);
        logic [2*MAXW-1:0] dp1;
        dp1 = {{MAXW{1'b0}}, d} + (2*MAXW)'(1);
        return (dp1 * dp1) > {{MAXW{1'b0}}, num};
    endfunction

endpackage

// File: rtl/prime_sched_if.sv
// Request/response bundle between the requesters, the response consumer and prime_sched.
interface prime_sched_if
    import prime_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_num;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_prime;
    logic [W-1:0]      rsp_num;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    modport master (
        output req_valid, req_num, rsp_ready,
        input  req_ready, rsp_valid, rsp_prime, rsp_num, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_num, rsp_ready,
        output req_ready, rsp_valid, rsp_prime, rsp_num, rsp_id, busy
    );

endinterface

// File: rtl/prime_trial_engine.sv
// Sequential trial-division engine: one divisor per cycle, early exit on a factor or past sqrt(num).
module prime_trial_engine
    import prime_sched_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] num_i,
    output logic         done_o,
    output logic         is_prime_o
);
    localparam int DW = W / 2 + 1;

    logic [W-1:0]  num_q, num_d;
    logic [DW-1:0] d_q, d_d;
    logic          active_q, active_d;
    logic          trivial, divides, past_root;

    // Operands below 4 are answered in the start cycle; larger ones iterate from d=2.
    always_comb begin
        trivial    = num_i < W'(4);
        divides    = (num_q % W'(d_q)) == '0;
        past_root  = isqrt_bound(MAXW'(d_q), MAXW'(num_q));
        num_d      = num_q;
        d_d        = d_q;
        active_d   = active_q;
        done_o     = 1'b0;
        is_prime_o = 1'b0;
        if (active_q) begin
            if (divides || past_root) begin
                done_o     = 1'b1;
                is_prime_o = !divides;
                active_d   = 1'b0;
            end else begin
                d_d = d_q + DW'(1);
            end
        end else if (start_i) begin
            if (trivial) begin
                done_o     = 1'b1;
                is_prime_o = num_i >= W'(2);
            end else begin
                num_d    = num_i;
                d_d      = DW'(2);
                active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q    <= '0;
            d_q      <= DW'(2);
            active_q <= 1'b0;
        end else begin
            num_q    <= num_d;
            d_q      <= d_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/prime_sched.sv
// Round-robin front end sharing one prime_trial_engine among NREQ requesters.
module prime_sched
    import prime_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    prime_sched_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d;
    logic [IDW-1:0]  grant_idx, cand;
    logic [W-1:0]    num_q, num_d;
    logic            prime_q, prime_d;
    logic            found, accept, eng_start, eng_done, eng_prime;
    logic [NREQ-1:0] ready;
    logic [W-1:0]    req_nums [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_nums[g] = bus.req_num[g*W +: W];
    end

    // Search begins just after the last served requester so nobody is starved.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        ready = '0;
        if (state_q == IDLE && found && !rst) begin
            ready[grant_idx] = 1'b1;
        end
        accept = |ready;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        num_d     = num_q;
        prime_d   = prime_q;
        eng_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    eng_start = 1'b1;
                    ptr_d     = grant_idx;
                    id_d      = grant_idx;
                    num_d     = req_nums[grant_idx];
                    if (eng_done) begin
                        state_d = DONE;
                        prime_d = eng_prime;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (eng_done) begin
                    state_d = DONE;
                    prime_d = eng_prime;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            num_q   <= '0;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            num_q   <= num_d;
            prime_q <= prime_d;
        end
    end

    prime_trial_engine #(.W(W)) u_engine (
        .clk        (clk),
        .rst        (rst),
        .start_i    (eng_start),
        .num_i      (req_nums[grant_idx]),
        .done_o     (eng_done),
        .is_prime_o (eng_prime)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_prime = prime_q;
    assign bus.rsp_num   = num_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
